axi4_master_ot: RTL and testbench

- AXI4 master, next generation of the single-outstanding master.
- Supports up to MAX_OUTSTANDING read and MAX_OUTSTANDING write bursts in flight, with rolling IDs.
- Generates WLAST internally from queued burst lengths and tracks outstanding-transaction counts.
- Sits between NPU DMA engines and the SoC interconnect.

---
 rtl/axi4_master_ot_if.sv | 82 ++++++++
 rtl/axi4_master_ot.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi4_master_ot.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_master_ot_if.sv
// AXI4 master-side bus bundle for axi4_master_ot: AW, W, B, AR and R channels.
// The master modport belongs to the DMA-facing master; the slave modport belongs to the interconnect or a bench model.
interface axi4_master_ot_if #(
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ADDR_WIDTH = 40,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_LEN_WIDTH  = 8
);
   // Every channel transfers on a cycle where valid && ready are both high.
   // A raised valid and its payload stay stable until that cycle.
   logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
   logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
   logic [AXI_LEN_WIDTH-1:0]    m_axi_awlen;
   logic [2:0]                  m_axi_awsize;
   logic [1:0]                  m_axi_awburst;
   logic                        m_axi_awlock;
   logic [3:0]                  m_axi_awcache;
   logic [2:0]                  m_axi_awprot;
   logic [3:0]                  m_axi_awqos;
   logic                        m_axi_awvalid;
   logic                        m_axi_awready;

   logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
   logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
   logic                        m_axi_wlast;
   logic                        m_axi_wvalid;
   logic                        m_axi_wready;

   logic [AXI_ID_WIDTH-1:0]     m_axi_bid;
   logic [1:0]                  m_axi_bresp;
   logic                        m_axi_bvalid;
   logic                        m_axi_bready;

   logic [AXI_ID_WIDTH-1:0]     m_axi_arid;
   logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr;
   logic [AXI_LEN_WIDTH-1:0]    m_axi_arlen;
   logic [2:0]                  m_axi_arsize;
   logic [1:0]                  m_axi_arburst;
   logic                        m_axi_arlock;
   logic [3:0]                  m_axi_arcache;
   logic [2:0]                  m_axi_arprot;
   logic [3:0]                  m_axi_arqos;
   logic                        m_axi_arvalid;
   logic                        m_axi_arready;

   logic [AXI_ID_WIDTH-1:0]     m_axi_rid;
   logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata;
   logic [1:0]                  m_axi_rresp;
   logic                        m_axi_rlast;
   logic                        m_axi_rvalid;
   logic                        m_axi_rready;

   modport master (
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bid, m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/axi4_master_ot.sv
// AXI4 master with up to MAX_OUTSTANDING bursts per direction, rolling IDs and WLAST from a burst-length FIFO.
// Optional macro AXI4_MASTER_4K_CHECK_EN drops requests that cross a 4 KB page and pulses boundary_err.
module axi4_master_ot #(
   parameter int AXI_DATA_WIDTH  = 128,
   parameter int AXI_ADDR_WIDTH  = 40,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int AXI_LEN_WIDTH   = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     wr_req,
   output logic                                     wr_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]                wr_addr,
   input  logic [AXI_LEN_WIDTH-1:0]                 wr_len,
   input  logic                                     wd_valid,
   output logic                                     wd_ready,
   input  logic [AXI_DATA_WIDTH-1:0]                wd_data,
   input  logic [AXI_DATA_WIDTH/8-1:0]              wd_strb,
   output logic                                     wr_done,
   output logic [1:0]                               wr_resp,
   output logic [AXI_ID_WIDTH-1:0]                  wr_id,
   input  logic                                     rd_req,
   output logic                                     rd_ready,
   input  logic [AXI_ADDR_WIDTH-1:0]                rd_addr,
   input  logic [AXI_LEN_WIDTH-1:0]                 rd_len,
   output logic                                     rd_valid,
   output logic [AXI_DATA_WIDTH-1:0]                rd_data,
   output logic [1:0]                               rd_resp,
   output logic                                     rd_last,
   output logic [AXI_ID_WIDTH-1:0]                  rd_id,
   input  logic                                     rd_accept,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     wr_os,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     rd_os,
   output logic [1:0]                               err_sticky,
   input  logic                                     err_clr,
   output logic                                     boundary_err,
   axi4_master_ot_if.master                         m_axi
);
   localparam int              BYTES    = AXI_DATA_WIDTH / 8;
   localparam logic [2:0]      SIZE     = 3'($clog2(BYTES));
   localparam int              OSW      = $clog2(MAX_OUTSTANDING + 1);
   localparam int              PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [OSW-1:0]  MAX_OS   = OSW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0]   LAST_PTR = PW'(MAX_OUTSTANDING - 1);

   logic                      r_awvalid;
   logic [AXI_ID_WIDTH-1:0]   r_awid;
   logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [AXI_LEN_WIDTH-1:0]  r_awlen;
   logic [AXI_ID_WIDTH-1:0]   r_wr_id_cnt;
   logic [OSW-1:0]            r_wr_os;

   logic                      r_arvalid;
   logic [AXI_ID_WIDTH-1:0]   r_arid;
   logic [AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [AXI_LEN_WIDTH-1:0]  r_arlen;
   logic [AXI_ID_WIDTH-1:0]   r_rd_id_cnt;
   logic [OSW-1:0]            r_rd_os;

   logic [AXI_LEN_WIDTH-1:0]  r_fifo_mem [MAX_OUTSTANDING];
   logic [PW-1:0]             r_fifo_wptr;
   logic [PW-1:0]             r_fifo_rptr;
   logic [OSW-1:0]            r_fifo_cnt;
   logic [AXI_LEN_WIDTH-1:0]  r_beat_cnt;
   logic [1:0]                r_err_sticky;

   logic w_wr_acc, w_wr_issue, w_aw_hs, w_b_dec;
   logic w_rd_acc, w_rd_issue, w_ar_hs, w_r_dec;
   logic w_fifo_empty, w_w_hs, w_wlast, w_fifo_pop, w_r_hs;

   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign wr_ready     = !r_awvalid && (r_wr_os < MAX_OS) && (r_fifo_cnt < MAX_OS);
   assign rd_ready     = !r_arvalid && (r_rd_os < MAX_OS);
   assign w_wr_acc     = wr_req && wr_ready;
   assign w_rd_acc     = rd_req && rd_ready;
   assign w_aw_hs      = r_awvalid && m_axi.m_axi_awready;
   assign w_ar_hs      = r_arvalid && m_axi.m_axi_arready;
   assign w_r_hs       = m_axi.m_axi_rvalid && rd_accept;
   // A response with nothing outstanding is stray and must not wrap the counter.
   assign w_b_dec      = m_axi.m_axi_bvalid && (r_wr_os != '0);
   assign w_r_dec      = w_r_hs && m_axi.m_axi_rlast && (r_rd_os != '0);

`ifdef AXI4_MASTER_4K_CHECK_EN
   logic r_boundary_err;
   logic w_wr_cross, w_rd_cross;

   function automatic logic crosses_4k(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                       input logic [AXI_LEN_WIDTH-1:0]  len);
      logic [31:0] end_byte;
      end_byte = 32'(addr[11:0]) + (32'(len) + 32'd1) * 32'(BYTES);
      return end_byte > 32'd4096;
   endfunction

   assign w_wr_cross = crosses_4k(wr_addr, wr_len);
   assign w_rd_cross = crosses_4k(rd_addr, rd_len);
   assign w_wr_issue = w_wr_acc && !w_wr_cross;
   assign w_rd_issue = w_rd_acc && !w_rd_cross;

   always_ff @(posedge clk) begin
      if (!rst_n) r_boundary_err <= 1'b0;
      else        r_boundary_err <= (w_wr_acc && w_wr_cross) || (w_rd_acc && w_rd_cross);
   end
   assign boundary_err = r_boundary_err;
`else
   assign w_wr_issue   = w_wr_acc;
   assign w_rd_issue   = w_rd_acc;
   assign boundary_err = 1'b0;
`endif

   // AW: fields are captured at acceptance and frozen until the slave takes them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_awvalid   <= 1'b0;
         r_awid      <= '0;
         r_awaddr    <= '0;
         r_awlen     <= '0;
         r_wr_id_cnt <= '0;
      end else if (w_wr_issue) begin
         r_awvalid <= 1'b1;
         r_awid    <= r_wr_id_cnt;
         r_awaddr  <= wr_addr;
         r_awlen   <= wr_len;
      end else if (w_aw_hs) begin
         r_awvalid   <= 1'b0;
         r_wr_id_cnt <= r_wr_id_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_os <= '0;
      end else begin
         case ({w_aw_hs, w_b_dec})
            2'b10:   r_wr_os <= r_wr_os + 1'b1;
            2'b01:   r_wr_os <= r_wr_os - 1'b1;
            default: r_wr_os <= r_wr_os;
         endcase
      end
   end

   assign w_wlast    = !w_fifo_empty && (r_beat_cnt == r_fifo_mem[r_fifo_rptr]);
   assign w_w_hs     = wd_valid && !w_fifo_empty && m_axi.m_axi_wready;
   assign w_fifo_pop = w_w_hs && w_wlast;

   always_ff @(posedge clk) begin
      if (w_wr_issue) r_fifo_mem[r_fifo_wptr] <= wr_len;
   end

   // Length FIFO is pushed at acceptance so W beats may run ahead of AW.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fifo_wptr <= '0;
         r_fifo_rptr <= '0;
         r_fifo_cnt  <= '0;
         r_beat_cnt  <= '0;
      end else begin
         if (w_wr_issue)
            r_fifo_wptr <= (r_fifo_wptr == LAST_PTR) ? '0 : r_fifo_wptr + 1'b1;
         if (w_fifo_pop)
            r_fifo_rptr <= (r_fifo_rptr == LAST_PTR) ? '0 : r_fifo_rptr + 1'b1;
         case ({w_wr_issue, w_fifo_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
         if (w_fifo_pop)  r_beat_cnt <= '0;
         else if (w_w_hs) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_arvalid   <= 1'b0;
         r_arid      <= '0;
         r_araddr    <= '0;
         r_arlen     <= '0;
         r_rd_id_cnt <= '0;
      end else if (w_rd_issue) begin
         r_arvalid <= 1'b1;
         r_arid    <= r_rd_id_cnt;
         r_araddr  <= rd_addr;
         r_arlen   <= rd_len;
      end else if (w_ar_hs) begin
         r_arvalid   <= 1'b0;
         r_rd_id_cnt <= r_rd_id_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_os <= '0;
      end else begin
         case ({w_ar_hs, w_r_dec})
            2'b10:   r_rd_os <= r_rd_os + 1'b1;
            2'b01:   r_rd_os <= r_rd_os - 1'b1;
            default: r_rd_os <= r_rd_os;
         endcase
      end
   end

   // Clear wins over a same-cycle error so software never loses a clear.
   always_ff @(posedge clk) begin
      if (!rst_n || err_clr) begin
         r_err_sticky <= 2'b00;
      end else begin
         if (m_axi.m_axi_bvalid && m_axi.m_axi_bresp[1]) r_err_sticky[0] <= 1'b1;
         if (w_r_hs && m_axi.m_axi_rresp[1])             r_err_sticky[1] <= 1'b1;
      end
   end

   assign m_axi.m_axi_awid    = r_awid;
   assign m_axi.m_axi_awaddr  = r_awaddr;
   assign m_axi.m_axi_awlen   = r_awlen;
   assign m_axi.m_axi_awsize  = SIZE;
   assign m_axi.m_axi_awburst = 2'b01;
   assign m_axi.m_axi_awlock  = 1'b0;
   assign m_axi.m_axi_awcache = 4'b0011;
   assign m_axi.m_axi_awprot  = 3'b000;
   assign m_axi.m_axi_awqos   = 4'b0000;
   assign m_axi.m_axi_awvalid = r_awvalid;

   assign m_axi.m_axi_wdata   = wd_data;
   assign m_axi.m_axi_wstrb   = wd_strb;
   assign m_axi.m_axi_wlast   = w_wlast;
   assign m_axi.m_axi_wvalid  = wd_valid && !w_fifo_empty;
   assign wd_ready            = m_axi.m_axi_wready && !w_fifo_empty;

   assign m_axi.m_axi_bready  = 1'b1;
   assign wr_done             = m_axi.m_axi_bvalid;
   assign wr_resp             = m_axi.m_axi_bresp;
   assign wr_id               = m_axi.m_axi_bid;

   assign m_axi.m_axi_arid    = r_arid;
   assign m_axi.m_axi_araddr  = r_araddr;
   assign m_axi.m_axi_arlen   = r_arlen;
   assign m_axi.m_axi_arsize  = SIZE;
   assign m_axi.m_axi_arburst = 2'b01;
   assign m_axi.m_axi_arlock  = 1'b0;
   assign m_axi.m_axi_arcache = 4'b0011;
   assign m_axi.m_axi_arprot  = 3'b000;
   assign m_axi.m_axi_arqos   = 4'b0000;
   assign m_axi.m_axi_arvalid = r_arvalid;

   assign rd_valid            = m_axi.m_axi_rvalid;
   assign rd_data             = m_axi.m_axi_rdata;
   assign rd_resp             = m_axi.m_axi_rresp;
   assign rd_last             = m_axi.m_axi_rlast;
   assign rd_id               = m_axi.m_axi_rid;
   assign m_axi.m_axi_rready  = rd_accept;

   assign wr_os      = r_wr_os;
   assign rd_os      = r_rd_os;
   assign err_sticky = r_err_sticky;
endmodule

// File: tb/tb_axi4_master_ot.sv
// Directed bench for axi4_master_ot: the bench plays the AXI slave and checks against hand-computed values.
module tb_axi4_master_ot;
  localparam int DW  = 128;
  localparam int AW  = 40;
  localparam int IDW = 4;
  localparam int LW  = 8;
  localparam int MO  = 4;

  logic clk, rst_n;
  logic wr_req, wr_ready, wd_valid, wd_ready, wr_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] wr_len, rd_len;
  logic [DW-1:0] wd_data, rd_data;
  logic [DW/8-1:0] wd_strb;
  logic [1:0] wr_resp, rd_resp, err_sticky;
  logic [IDW-1:0] wr_id, rd_id;
  logic rd_req, rd_ready, rd_valid, rd_last, rd_accept, err_clr, boundary_err;
  logic [2:0] wr_os, rd_os;

  int n_cmp = 0;
  int n_bad = 0;

  axi4_master_ot_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                      .AXI_ID_WIDTH(IDW), .AXI_LEN_WIDTH(LW)) bus ();

  axi4_master_ot #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW),
                   .AXI_LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_len(wr_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .wr_done(wr_done), .wr_resp(wr_resp), .wr_id(wr_id),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
    .rd_id(rd_id), .rd_accept(rd_accept),
    .wr_os(wr_os), .rd_os(rd_os), .err_sticky(err_sticky), .err_clr(err_clr),
    .boundary_err(boundary_err), .m_axi(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wd_valid = 1'b0; err_clr = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_rvalid = 1'b0; rd_accept = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    wr_req = 1'b1; wr_addr = a; wr_len = l;
    #1;
    while (!wr_ready && n < 50) begin step(); n++; end
    n_cmp++;
    if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_wait: got ready=%b want 1", wr_ready); end
    step();
    wr_req = 1'b0;
  endtask

  task automatic rd_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    rd_req = 1'b1; rd_addr = a; rd_len = l;
    #1;
    while (!rd_ready && n < 50) begin step(); n++; end
    n_cmp++;
    if (rd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_cmd_wait: got ready=%b want 1", rd_ready); end
    step();
    rd_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.m_axi_awvalid !== 1'b0) begin n_bad++; $display("FAIL rst_awvalid: got %b want 0", bus.m_axi_awvalid); end
    n_cmp++; if (bus.m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL rst_arvalid: got %b want 0", bus.m_axi_arvalid); end
    n_cmp++; if (wr_os !== 3'd0) begin n_bad++; $display("FAIL rst_wr_os: got %0d want 0", wr_os); end
    n_cmp++; if (rd_os !== 3'd0) begin n_bad++; $display("FAIL rst_rd_os: got %0d want 0", rd_os); end
    n_cmp++; if (err_sticky !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b want 00", err_sticky); end
    n_cmp++; if (wr_ready !== 1'b1 || rd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b%b want 11", wr_ready, rd_ready); end
    bus.m_axi_wready = 1'b1; #1;
    n_cmp++; if (wd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wd_ready: got %b want 0", wd_ready); end
    bus.m_axi_wready = 1'b0;
    n_cmp++; if (boundary_err !== 1'b0) begin n_bad++; $display("FAIL rst_bnd: got %b want 0", boundary_err); end
    n_cmp++; if (bus.m_axi_awsize !== 3'd4 || bus.m_axi_arsize !== 3'd4) begin n_bad++; $display("FAIL rst_size: got %0d/%0d want 4", bus.m_axi_awsize, bus.m_axi_arsize); end
    n_cmp++; if (bus.m_axi_awburst !== 2'b01 || bus.m_axi_awcache !== 4'b0011 || bus.m_axi_arcache !== 4'b0011) begin
      n_bad++; $display("FAIL rst_fixed: got burst=%b cache=%b/%b want 01 0011", bus.m_axi_awburst, bus.m_axi_awcache, bus.m_axi_arcache); end
    n_cmp++; if (bus.m_axi_bready !== 1'b1) begin n_bad++; $display("FAIL rst_bready: got %b want 1", bus.m_axi_bready); end
  endtask

  task automatic test_aw_outstanding();
    logic [AW-1:0] exp_addr;
    bus.m_axi_awready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 40'h1000 + 40'(i) * 40'h100;
      wr_cmd(exp_addr, 8'd3);
      n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'(i)) begin
        n_bad++; $display("FAIL aw_issue%0d: got valid=%b id=%0d want 1 %0d", i, bus.m_axi_awvalid, bus.m_axi_awid, i); end
      n_cmp++; if (bus.m_axi_awaddr !== exp_addr || bus.m_axi_awlen !== 8'd3) begin
        n_bad++; $display("FAIL aw_fields%0d: got %h/%0d want %h/3", i, bus.m_axi_awaddr, bus.m_axi_awlen, exp_addr); end
      step();
      n_cmp++; if (wr_os !== 3'(i + 1)) begin n_bad++; $display("FAIL aw_os%0d: got %0d want %0d", i, wr_os, i + 1); end
    end
    wr_req = 1'b1; wr_addr = 40'h5000; wr_len = 8'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (wr_ready !== 1'b0 || bus.m_axi_awvalid !== 1'b0) begin
        n_bad++; $display("FAIL aw_stall%0d: got ready=%b awvalid=%b want 0 0", c, wr_ready, bus.m_axi_awvalid); end
      step();
    end
    wr_req = 1'b0;
  endtask

  task automatic test_w_beats();
    int beat = 0;
    int cyc = 0;
    logic hs;
    wd_valid = 1'b1; wd_strb = '1;
    while (beat < 16 && cyc < 100) begin
      bus.m_axi_wready = (cyc % 2 == 0);
      wd_data = DW'(beat);
      #1;
      hs = bus.m_axi_wvalid && bus.m_axi_wready;
      n_cmp++; if (wd_ready !== bus.m_axi_wready) begin n_bad++; $display("FAIL w_ready%0d: got %b want %b", cyc, wd_ready, bus.m_axi_wready); end
      if (hs) begin
        n_cmp++; if (bus.m_axi_wlast !== ((beat % 4) == 3)) begin
          n_bad++; $display("FAIL w_last_beat%0d: got %b want %b", beat + 1, bus.m_axi_wlast, (beat % 4) == 3); end
        n_cmp++; if (bus.m_axi_wdata !== DW'(beat)) begin n_bad++; $display("FAIL w_data%0d: got %0h want %0h", beat, bus.m_axi_wdata, beat); end
        beat++;
      end
      step();
      cyc++;
    end
    n_cmp++; if (beat != 16) begin n_bad++; $display("FAIL w_count: got %0d want 16", beat); end
    bus.m_axi_wready = 1'b1; #1;
    n_cmp++; if (wd_ready !== 1'b0 || bus.m_axi_wvalid !== 1'b0) begin
      n_bad++; $display("FAIL w_empty: got wd_ready=%b wvalid=%b want 0 0", wd_ready, bus.m_axi_wvalid); end
    wd_valid = 1'b0; bus.m_axi_wready = 1'b0;
  endtask

  task automatic test_b_release();
    wr_req = 1'b1; wr_addr = 40'h5000; wr_len = 8'd0;
    #1;
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL b_prestall: got %b want 0", wr_ready); end
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bid = 4'd0; bus.m_axi_bresp = 2'b00;
    #1;
    n_cmp++; if (wr_done !== 1'b1 || wr_id !== 4'd0 || wr_resp !== 2'b00) begin
      n_bad++; $display("FAIL b_done: got done=%b id=%0d resp=%b want 1 0 00", wr_done, wr_id, wr_resp); end
    step();
    bus.m_axi_bvalid = 1'b0;
    #1;
    n_cmp++; if (wr_os !== 3'd3 || wr_ready !== 1'b1) begin n_bad++; $display("FAIL b_release: got os=%0d ready=%b want 3 1", wr_os, wr_ready); end
    step();
    wr_req = 1'b0;
    n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'd4) begin
      n_bad++; $display("FAIL b_fifth_aw: got valid=%b id=%0d want 1 4", bus.m_axi_awvalid, bus.m_axi_awid); end
    step();
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bid = 4'd1; step();
    bus.m_axi_bid = 4'd2; step();
    bus.m_axi_bvalid = 1'b0;
    n_cmp++; if (wr_os !== 3'd2) begin n_bad++; $display("FAIL b_drain: got %0d want 2", wr_os); end
  endtask

  task automatic test_b_aw_same();
    bus.m_axi_awready = 1'b0;
    wr_cmd(40'h6000, 8'd0);
    n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'd5) begin
      n_bad++; $display("FAIL same_aw: got valid=%b id=%0d want 1 5", bus.m_axi_awvalid, bus.m_axi_awid); end
    step();
    n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awaddr !== 40'h6000 || bus.m_axi_awid !== 4'd5) begin
      n_bad++; $display("FAIL same_hold: got valid=%b addr=%h id=%0d want 1 6000 5", bus.m_axi_awvalid, bus.m_axi_awaddr, bus.m_axi_awid); end
    bus.m_axi_awready = 1'b1; bus.m_axi_bvalid = 1'b1; bus.m_axi_bid = 4'd3;
    step();
    bus.m_axi_bvalid = 1'b0;
    n_cmp++; if (wr_os !== 3'd2 || bus.m_axi_awvalid !== 1'b0) begin
      n_bad++; $display("FAIL same_os: got os=%0d awvalid=%b want 2 0", wr_os, bus.m_axi_awvalid); end
  endtask

  task automatic test_read_err();
    int beat = 0;
    int cyc = 0;
    logic hs;
    bus.m_axi_arready = 1'b1;
    rd_cmd(40'h2000, 8'd7);
    n_cmp++; if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_arlen !== 8'd7 || bus.m_axi_arid !== 4'd0 || bus.m_axi_araddr !== 40'h2000) begin
      n_bad++; $display("FAIL rd_ar: got valid=%b len=%0d id=%0d addr=%h want 1 7 0 2000", bus.m_axi_arvalid, bus.m_axi_arlen, bus.m_axi_arid, bus.m_axi_araddr); end
    step();
    n_cmp++; if (rd_os !== 3'd1) begin n_bad++; $display("FAIL rd_os_inc: got %0d want 1", rd_os); end
    while (beat < 8 && cyc < 100) begin
      rd_accept = (cyc % 2 == 1);
      bus.m_axi_rvalid = 1'b1; bus.m_axi_rid = 4'd0;
      bus.m_axi_rdata = DW'(beat + 'hA0);
      bus.m_axi_rresp = (beat == 3) ? 2'b10 : 2'b00;
      bus.m_axi_rlast = (beat == 7);
      #1;
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== DW'(beat + 'hA0) || bus.m_axi_rready !== rd_accept || rd_last !== (beat == 7)) begin
        n_bad++; $display("FAIL rd_pass%0d: got v=%b d=%0h rdy=%b last=%b", beat, rd_valid, rd_data, bus.m_axi_rready, rd_last); end
      hs = rd_accept;
      step();
      if (hs) begin
        beat++;
        n_cmp++; if (rd_os !== ((beat == 8) ? 3'd0 : 3'd1)) begin n_bad++; $display("FAIL rd_os_beat%0d: got %0d want %0d", beat, rd_os, (beat == 8) ? 0 : 1); end
        n_cmp++; if (err_sticky !== ((beat >= 4) ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL rd_err_beat%0d: got %b", beat, err_sticky); end
      end
      cyc++;
    end
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; rd_accept = 1'b0;
    n_cmp++; if (beat != 8) begin n_bad++; $display("FAIL rd_count: got %0d want 8", beat); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_cmp++; if (err_sticky !== 2'b00) begin n_bad++; $display("FAIL err_clr: got %b want 00", err_sticky); end
    err_clr = 1'b1; bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b10; bus.m_axi_bid = 4'd4;
    #1;
    n_cmp++; if (wr_done !== 1'b1 || wr_resp !== 2'b10 || wr_id !== 4'd4) begin
      n_bad++; $display("FAIL b_err_pass: got %b %b %0d want 1 10 4", wr_done, wr_resp, wr_id); end
    step();
    n_cmp++; if (err_sticky !== 2'b00) begin n_bad++; $display("FAIL err_clr_prio: got %b want 00", err_sticky); end
    err_clr = 1'b0; bus.m_axi_bid = 4'd5; step();
    bus.m_axi_bvalid = 1'b0;
    n_cmp++; if (err_sticky !== 2'b01 || wr_os !== 3'd0) begin
      n_bad++; $display("FAIL b_err_set: got err=%b os=%0d want 01 0", err_sticky, wr_os); end
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = 2'b00; step();
    bus.m_axi_bvalid = 1'b0;
    n_cmp++; if (wr_os !== 3'd0) begin n_bad++; $display("FAIL b_underflow: got %0d want 0", wr_os); end
  endtask

  task automatic test_arid_wrap();
    do_reset();
    bus.m_axi_arready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rd_cmd(40'h3000 + 40'(i) * 40'h40, 8'd0);
      n_cmp++; if (bus.m_axi_arid !== 4'(i)) begin n_bad++; $display("FAIL arid%0d: got %0d want %0d", i, bus.m_axi_arid, i % 16); end
      step();
      bus.m_axi_rvalid = 1'b1; bus.m_axi_rlast = 1'b1; bus.m_axi_rresp = 2'b00; rd_accept = 1'b1;
      step();
      bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; rd_accept = 1'b0;
    end
    n_cmp++; if (rd_os !== 3'd0) begin n_bad++; $display("FAIL arid_os: got %0d want 0", rd_os); end
  endtask

  task automatic test_4k();
    do_reset();
    bus.m_axi_awready = 1'b1;
    wr_cmd(40'h0FC0, 8'd7);
`ifdef AXI4_MASTER_4K_CHECK_EN
    n_cmp++; if (boundary_err !== 1'b1 || bus.m_axi_awvalid !== 1'b0) begin
      n_bad++; $display("FAIL bnd_pulse: got err=%b awvalid=%b want 1 0", boundary_err, bus.m_axi_awvalid); end
    step();
    n_cmp++; if (boundary_err !== 1'b0 || wr_os !== 3'd0) begin
      n_bad++; $display("FAIL bnd_clear: got err=%b os=%0d want 0 0", boundary_err, wr_os); end
    wr_cmd(40'h2000, 8'd0);
    n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'd0) begin
      n_bad++; $display("FAIL bnd_next_id: got valid=%b id=%0d want 1 0", bus.m_axi_awvalid, bus.m_axi_awid); end
`else
    n_cmp++; if (boundary_err !== 1'b0 || bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'd0 || bus.m_axi_awaddr !== 40'h0FC0) begin
      n_bad++; $display("FAIL bnd_off_issue: got err=%b valid=%b id=%0d addr=%h want 0 1 0 fc0", boundary_err, bus.m_axi_awvalid, bus.m_axi_awid, bus.m_axi_awaddr); end
    step();
    wr_cmd(40'h2000, 8'd0);
    n_cmp++; if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_awid !== 4'd1 || boundary_err !== 1'b0) begin
      n_bad++; $display("FAIL bnd_off_next: got valid=%b id=%0d err=%b want 1 1 0", bus.m_axi_awvalid, bus.m_axi_awid, boundary_err); end
`endif
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.m_axi_awready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_cmd(40'h7000 + 40'(i) * 40'h100, 8'd3);
      step();
    end
    bus.m_axi_awready = 1'b0;
    wr_cmd(40'h8000, 8'd3);
    wd_valid = 1'b1; bus.m_axi_wready = 1'b1; wd_data = '0;
    step(); step();
    wd_valid = 1'b0;
    n_cmp++; if (wr_os !== 3'd3 || bus.m_axi_awvalid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got os=%0d awvalid=%b want 3 1", wr_os, bus.m_axi_awvalid); end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_cmp++; if (wr_os !== 3'd0 || bus.m_axi_awvalid !== 1'b0 || wd_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst: got os=%0d awvalid=%b wd_ready=%b want 0 0 0", wr_os, bus.m_axi_awvalid, wd_ready); end
    bus.m_axi_awready = 1'b1;
    wr_cmd(40'h9000, 8'd1);
    step();
    wd_valid = 1'b1; #1;
    n_cmp++; if (bus.m_axi_wvalid !== 1'b1 || bus.m_axi_wlast !== 1'b0) begin
      n_bad++; $display("FAIL mid_beat0: got wvalid=%b wlast=%b want 1 0", bus.m_axi_wvalid, bus.m_axi_wlast); end
    step();
    n_cmp++; if (bus.m_axi_wlast !== 1'b1) begin n_bad++; $display("FAIL mid_beat1: got wlast=%b want 1", bus.m_axi_wlast); end
    step();
    wd_valid = 1'b0; #1;
    n_cmp++; if (wd_ready !== 1'b0) begin n_bad++; $display("FAIL mid_pop: got wd_ready=%b want 0", wd_ready); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wd_valid = 1'b0; err_clr = 1'b0; rd_accept = 1'b0;
    wr_addr = '0; wr_len = '0; rd_addr = '0; rd_len = '0; wd_data = '0; wd_strb = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_arready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bid = '0; bus.m_axi_bresp = '0;
    bus.m_axi_rvalid = 1'b0; bus.m_axi_rid = '0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0;
    test_reset();
    test_aw_outstanding();
    test_w_beats();
    test_b_release();
    test_b_aw_same();
    test_read_err();
    test_arid_wrap();
    test_4k();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
